// File: rtl/alu_seq_pkg.sv
// Shared types and default widths for the ALU command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_seq_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int TAG_W_DEF     = 4;
  localparam int RSP_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_XOR = 2'b10,
    OP_MUL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Response queue holding {result, tag} entries in arrival order.
// Latency: an entry pushed at edge N is visible at the head right after edge N.
// Backpressure: pushes while full are dropped; the caller gates on count.
module alu_rsp_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = RSP_DEPTH_DEF,
  parameter int WIDTH = DATA_W_DEF + TAG_W_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  // An empty queue presents zeros so the payload outputs are clean after reset.
  assign head    = valid ? mem[rd_ptr] : '0;

  // Storage write; contents need no reset because count qualifies the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Sequences one command at a time through an external registered ALU and queues tagged results.
// Latency: accept at edge N, result enters the response queue at edge N+2.
// Backpressure: cmd_ready drops while a command is in flight or the response queue is full.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_op1,
  input  logic [DATA_W-1:0] cmd_op2,
  input  logic [1:0]        cmd_opcode,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [1:0]        alu_operation,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] ISSUE   = ST_ISSUE;
  localparam logic [1:0] CAPTURE = ST_CAPTURE;
  localparam int         CW      = $clog2(RSP_DEPTH) + 1;

  logic [1:0]              state;
  logic [TAG_W-1:0]        tag_q;
  logic [CW-1:0]           count;
  logic [DATA_W+TAG_W-1:0] head;
  logic                    accept;
  logic                    push;
  logic                    pop;

  // Ready depends only on registered state, so there is no path from cmd_valid.
  assign cmd_ready = (state == IDLE) && (count < CW'(RSP_DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign push      = (state == CAPTURE);
  assign pop       = rsp_valid && rsp_ready;
  assign {rsp_data, rsp_tag} = head;
  assign busy      = (state != IDLE) || rsp_valid;

  // IDLE -> ISSUE on acceptance, then one cycle each in ISSUE and CAPTURE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= ISSUE;
        ISSUE:   state <= CAPTURE;
        CAPTURE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operands and tag load only on acceptance so the ALU inputs stay quiet while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op1       <= '0;
      alu_op2       <= '0;
      alu_operation <= 2'b00;
      tag_q         <= '0;
    end else if (accept) begin
      alu_op1       <= cmd_op1;
      alu_op2       <= cmd_op2;
      alu_operation <= cmd_opcode;
      tag_q         <= cmd_tag;
    end
  end

  alu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W + TAG_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({alu_result, tag_q}),
    .pop       (pop),
    .head      (head),
    .valid     (rsp_valid),
    .count     (count)
  );

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: transaction-level model plus directed and random stimulus.
// Latency: models the two-edge accept-to-queue delay of the sequencer.
// Backpressure: drives random rsp_ready stalls and held cmd_valid.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int DW    = 16;
  localparam int TW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_op1, cmd_op2;
  logic [1:0]    cmd_opcode;
  logic [TW-1:0] cmd_tag;
  logic [DW-1:0] alu_op1, alu_op2;
  logic [1:0]    alu_operation;
  logic [DW-1:0] alu_result;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          busy;

  int errors = 0;
  int checks = 0;

  alu_cmd_sequencer #(.DATA_W(DW), .TAG_W(TW), .RSP_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op1       (cmd_op1),
    .cmd_op2       (cmd_op2),
    .cmd_opcode    (cmd_opcode),
    .cmd_tag       (cmd_tag),
    .alu_op1       (alu_op1),
    .alu_op2       (alu_op2),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_tag       (rsp_tag),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Plain modulo-2^16 arithmetic for the four opcodes.
  function automatic logic [DW-1:0] ref_alu(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    p = (2*DW)'(a) * (2*DW)'(b);
    case (op_e'(op))
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      default: return p[DW-1:0];
    endcase
  endfunction

  // Stand-in for the external registered ALU sharing the reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) alu_result <= '0;
    else     alu_result <= ref_alu(alu_operation, alu_op1, alu_op2);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction model: queue of expected responses and a countdown for the command in flight.
  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } rsp_t;

  rsp_t          expq[$];
  int            left = 0;
  logic [DW-1:0] pend_data;
  logic [TW-1:0] pend_tag;
  logic [DW-1:0] m_op1 = '0, m_op2 = '0;
  logic [1:0]    m_op = '0;

  initial begin
    bit exp_rdy, exp_vld;
    forever begin
      @(negedge clk);
      if (rst) begin
        expq.delete();
        left  = 0;
        m_op1 = '0;
        m_op2 = '0;
        m_op  = '0;
      end else begin
        exp_rdy = (left == 0) && (expq.size() < DEPTH);
        exp_vld = (expq.size() > 0);
        check("mon_cmd_ready", cmd_ready, exp_rdy);
        check("mon_rsp_valid", rsp_valid, exp_vld);
        check("mon_busy", busy, (left > 0) || exp_vld);
        if (exp_vld) begin
          check("mon_rsp_data", rsp_data, expq[0].data);
          check("mon_rsp_tag", rsp_tag, expq[0].tag);
        end
        check("mon_alu_op1", alu_op1, m_op1);
        check("mon_alu_op2", alu_op2, m_op2);
        check("mon_alu_operation", alu_operation, m_op);
        // Effects of the coming clock edge: pop first, then the capture push.
        if (exp_vld && rsp_ready) void'(expq.pop_front());
        if (left == 1) begin
          expq.push_back(rsp_t'({pend_data, pend_tag}));
          left = 0;
        end else if (left == 2) begin
          left = 1;
        end
        if (cmd_valid && exp_rdy) begin
          pend_data = ref_alu(cmd_opcode, cmd_op1, cmd_op2);
          pend_tag  = cmd_tag;
          m_op1     = cmd_op1;
          m_op2     = cmd_op2;
          m_op      = cmd_opcode;
          left      = 2;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] tag);
    int n = 0;
    cmd_opcode = op;
    cmd_op1    = a;
    cmd_op2    = b;
    cmd_tag    = tag;
    cmd_valid  = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("issue_timeout", 1'b1, 1'b0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tagname);
    check({tagname, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tagname, "_rsp_data"}, rsp_data, '0);
    check({tagname, "_rsp_tag"}, rsp_tag, '0);
    check({tagname, "_alu_op1"}, alu_op1, '0);
    check({tagname, "_alu_op2"}, alu_op2, '0);
    check({tagname, "_alu_operation"}, alu_operation, 2'b00);
    check({tagname, "_busy"}, busy, 1'b0);
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] a, b, res;
    logic [TW-1:0] tag;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int acc;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op1 = '0; cmd_op2 = '0; cmd_opcode = 2'b00; cmd_tag = '0;
    step(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    check("reset_cmd_ready", cmd_ready, 1'b1);

    // Directed arithmetic with hand-computed results, pinned at N+1 and N+2.
    vecs[0] = '{2'b00, 16'h0003, 16'h0004, 16'h0007, 4'd1};
    vecs[1] = '{2'b01, 16'h0001, 16'h0002, 16'hFFFF, 4'd2};
    vecs[2] = '{2'b11, 16'h0100, 16'h0100, 16'h0000, 4'd3};
    vecs[3] = '{2'b10, 16'hA5A5, 16'hFFFF, 16'h5A5A, 4'd4};
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      check("dir_cmd_ready_issue", cmd_ready, 1'b0);
      step(1);
      check("dir_rsp_early", rsp_valid, 1'b0);
      step(1);
      check("dir_rsp_valid", rsp_valid, 1'b1);
      check("dir_rsp_data", rsp_data, vecs[i].res);
      check("dir_rsp_tag", rsp_tag, vecs[i].tag);
    end
    step(2);

    // Fill the queue with rsp_ready low, then drain in order.
    rsp_ready = 1'b0;
    for (int t = 0; t < 4; t++) issue(2'b00, 16'(t), 16'h0010, 4'(t));
    step(2);
    check("full_cmd_ready", cmd_ready, 1'b0);
    step(3);
    check("full_cmd_ready_hold", cmd_ready, 1'b0);
    check("full_busy", busy, 1'b1);
    check("full_head_tag", rsp_tag, 4'd0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", rsp_valid, 1'b1);
      check("drain_tag", rsp_tag, 4'(k));
      check("drain_data", rsp_data, 16'(k) + 16'h0010);
      step(1);
    end
    check("drain_empty", rsp_valid, 1'b0);
    check("drain_cmd_ready", cmd_ready, 1'b1);

    // Pop coincides with the capture edge while one entry is queued.
    rsp_ready = 1'b0;
    issue(2'b10, 16'h1234, 16'h00FF, 4'd8);
    step(2);
    issue(2'b01, 16'h0000, 16'h0001, 4'd9);
    step(1);
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0;
    check("same_edge_valid", rsp_valid, 1'b1);
    check("same_edge_tag", rsp_tag, 4'd9);
    check("same_edge_data", rsp_data, 16'hFFFF);
    step(1);
    check("same_edge_hold_tag", rsp_tag, 4'd9);
    rsp_ready = 1'b1;
    step(1);
    check("same_edge_empty", rsp_valid, 1'b0);

    // cmd_valid held high: one acceptance every three cycles.
    acc = 0;
    cmd_opcode = 2'b00; cmd_op1 = 16'h0001; cmd_op2 = 16'h0001; cmd_tag = 4'd7;
    cmd_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (cmd_ready) acc++;
      step(1);
    end
    cmd_valid = 1'b0;
    check("held_valid_accepts", 32'(acc), 32'd4);
    step(4);

    // Reset while tag 5 is in ISSUE.
    rsp_ready = 1'b0;
    issue(2'b00, 16'h0005, 16'h0005, 4'd5);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    step(2);
    rst = 1'b0;
    check("midrst_cmd_ready", cmd_ready, 1'b1);
    step(6);
    check("midrst_no_rsp", rsp_valid, 1'b0);
    check("midrst_idle", busy, 1'b0);

    // Random traffic: heavy stalls first, then mostly free-flowing.
    for (int c = 0; c < 400; c++) begin
      cmd_valid  = ($urandom_range(0, 3) != 0);
      cmd_opcode = 2'($urandom_range(0, 3));
      cmd_op1    = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      cmd_op2    = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      cmd_tag    = 4'($urandom);
      rsp_ready  = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(1);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step(12);
    check("final_idle", busy, 1'b0);
    check("final_cmd_ready", cmd_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
